// File: rtl/dac_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dac_sched_pkg
// Description : Shared command codes, channel index width and FSM state
//               encoding for the DAC channel scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package dac_sched_pkg;

  // Channel index width; the block serves at most four DAC channels.
  localparam int CH_W   = 2;
  localparam int MAX_CH = 4;

  // Upper command byte of the 24-bit DAC word.
  localparam logic [7:0] CMD_WRITE_THROUGH = 8'h30;  // write and update output
  localparam logic [7:0] CMD_WRITE_CODE    = 8'h10;  // write input register only
  localparam logic [7:0] CMD_LOAD          = 8'h20;  // update selected outputs

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SCAN = 3'd1,
    ST_SEND = 3'd2,
    ST_WAIT = 3'd3,
    ST_LOAD = 3'd4
  } state_e;

  // Channel select bits of the command byte.
  function automatic logic [3:0] ch_onehot(input logic [CH_W-1:0] ch);
    return 4'(4'b0001 << ch);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sample_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : sample_tick_gen
// Description : Free-running interval counter. Counts 0..INTERVAL-1 and
//               asserts tick on the wrap cycle, so ticks are exactly
//               INTERVAL clocks apart.
// Revision    : 1.0 - initial release
// ============================================================================
module sample_tick_gen #(
  parameter int INTERVAL = 3624,
  parameter int CNT_W    = 24
) (
  input  logic clock,
  input  logic rstn,
  output logic tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(INTERVAL - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: wrap to zero after the last value of the interval
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (cnt_q == LAST) begin
      cnt_d = '0;
    end
  end

  // Counter register
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == LAST);

endmodule
`default_nettype wire

// File: rtl/dac_channel_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : dac_channel_scheduler
// Description : Holds the latest sample of up to four DAC channels and, once
//               per interval tick, sends one 24-bit command per channel with
//               fresh data to the DAC SPI driver over a send/busy handshake.
//               Optional macro DAC_LATCH_ALL_EN: channels are written with
//               CMD_WRITE_CODE and each non-empty frame ends with one
//               CMD_LOAD so all written channels update together.
// Revision    : 1.0 - initial release
// ============================================================================
module dac_channel_scheduler
  import dac_sched_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int DATA_W   = 16,
  parameter int INTERVAL = 3624,
  parameter int CNT_W    = 24
) (
  input  logic              clock,
  input  logic              rstn,
  input  logic              in_valid,
  input  logic [CH_W-1:0]   in_channel,
  input  logic [DATA_W-1:0] in_data,
  input  logic              spi_busy,
  output logic              dac_send,
  output logic [23:0]       dac_data,
  output logic              frame_active,
  output logic              frame_overrun,
  output logic [7:0]        overwrite_count
);

  // Scan index needs one extra bit so "last channel + 1" never wraps to 0.
  localparam int SCAN_W = CH_W + 1;
  localparam int PAD_W  = 16 - DATA_W;

`ifdef DAC_LATCH_ALL_EN
  localparam logic [7:0] CMD_CH = CMD_WRITE_CODE;
`else
  localparam logic [7:0] CMD_CH = CMD_WRITE_THROUGH;
`endif

  logic tick;

  state_e              state_q, state_d;
  logic [SCAN_W-1:0]   scan_idx_q, scan_idx_d;
  logic [CH_W-1:0]     last_ch_q, last_ch_d;
  logic                wait_first_q, wait_first_d;
  logic                dac_send_q, dac_send_d;
  logic [23:0]         dac_data_q, dac_data_d;
  logic                frame_active_q, frame_active_d;
  logic                overrun_q, overrun_d;
  logic [7:0]          ovw_q, ovw_d;
  logic [DATA_W-1:0]   sample_q [NUM_CH];
  logic [DATA_W-1:0]   sample_d [NUM_CH];
  logic [NUM_CH-1:0]   dirty_q, dirty_d;
`ifdef DAC_LATCH_ALL_EN
  logic [3:0]          sent_mask_q, sent_mask_d;
  logic                is_load_q, is_load_d;
`endif

  logic                found;
  logic [CH_W-1:0]     sel_ch;
  logic [NUM_CH-1:0]   sel_vec;
  logic [DATA_W-1:0]   sel_sample;
  logic [15:0]         sel_word;
  logic [NUM_CH-1:0]   clr_vec;
  logic                ovw_inc;

  sample_tick_gen #(
    .INTERVAL (INTERVAL),
    .CNT_W    (CNT_W)
  ) u_tick (
    .clock (clock),
    .rstn  (rstn),
    .tick  (tick)
  );

  // Pick the lowest dirty channel at or above the scan index
  always_comb begin
    found      = 1'b0;
    sel_ch     = '0;
    sel_vec    = '0;
    sel_sample = '0;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (dirty_q[c] && (SCAN_W'(c) >= scan_idx_q)) begin
        found      = 1'b1;
        sel_ch     = CH_W'(c);
        sel_vec    = '0;
        sel_vec[c] = 1'b1;
        sel_sample = sample_q[c];
      end
    end
    sel_word = 16'(16'(sel_sample) << PAD_W);
  end

  // Frame FSM: next state, command latch and handshake pulse
  always_comb begin
    state_d        = state_q;
    scan_idx_d     = scan_idx_q;
    last_ch_d      = last_ch_q;
    wait_first_d   = 1'b0;
    dac_send_d     = 1'b0;
    dac_data_d     = dac_data_q;
    frame_active_d = frame_active_q;
    overrun_d      = overrun_q | (tick && (state_q != ST_IDLE));
    clr_vec        = '0;
`ifdef DAC_LATCH_ALL_EN
    sent_mask_d    = sent_mask_q;
    is_load_d      = is_load_q;
`endif
    case (state_q)
      ST_IDLE: begin
        // frame_active stays high through the cycle the FSM lands in IDLE
        frame_active_d = 1'b0;
        if (tick) begin
          state_d        = ST_SCAN;
          scan_idx_d     = '0;
          frame_active_d = 1'b1;
`ifdef DAC_LATCH_ALL_EN
          sent_mask_d    = 4'h0;
          is_load_d      = 1'b0;
`endif
        end
      end
      ST_SCAN: begin
        if (found) begin
          dac_data_d = {CMD_CH | {4'h0, ch_onehot(sel_ch)}, sel_word};
          clr_vec    = sel_vec;
          last_ch_d  = sel_ch;
          state_d    = ST_SEND;
`ifdef DAC_LATCH_ALL_EN
          sent_mask_d = sent_mask_q | ch_onehot(sel_ch);
`endif
        end else begin
          state_d = ST_IDLE;
`ifdef DAC_LATCH_ALL_EN
          if (sent_mask_q != 4'h0) begin
            state_d = ST_LOAD;
          end
`endif
        end
      end
      ST_SEND: begin
        if (!spi_busy) begin
          dac_send_d   = 1'b1;
          wait_first_d = 1'b1;
          state_d      = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // The driver raises busy only after seeing the send pulse, so the
        // first WAIT cycle must not trust spi_busy.
        if (!wait_first_q && !spi_busy) begin
          state_d    = ST_SCAN;
          scan_idx_d = SCAN_W'(last_ch_q) + SCAN_W'(1);
`ifdef DAC_LATCH_ALL_EN
          if (is_load_q) begin
            state_d = ST_IDLE;
          end
`endif
        end
      end
`ifdef DAC_LATCH_ALL_EN
      ST_LOAD: begin
        dac_data_d = {CMD_LOAD | {4'h0, sent_mask_q}, 16'h0000};
        is_load_d  = 1'b1;
        state_d    = ST_SEND;
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sample capture; a write racing the latch of its own channel keeps dirty set
  always_comb begin
    sample_d = sample_q;
    dirty_d  = dirty_q & ~clr_vec;
    ovw_inc  = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (in_valid && (in_channel == CH_W'(c))) begin
        sample_d[c] = in_data;
        dirty_d[c]  = 1'b1;
        if (dirty_q[c] && !clr_vec[c]) begin
          ovw_inc = 1'b1;
        end
      end
    end
    ovw_d = ovw_q;
    if (ovw_inc && (ovw_q != 8'hFF)) begin
      ovw_d = ovw_q + 8'd1;
    end
  end

  // State and datapath registers
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      state_q        <= ST_IDLE;
      scan_idx_q     <= '0;
      last_ch_q      <= '0;
      wait_first_q   <= 1'b0;
      dac_send_q     <= 1'b0;
      dac_data_q     <= '0;
      frame_active_q <= 1'b0;
      overrun_q      <= 1'b0;
      ovw_q          <= '0;
      dirty_q        <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        sample_q[c] <= '0;
      end
`ifdef DAC_LATCH_ALL_EN
      sent_mask_q    <= 4'h0;
      is_load_q      <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      scan_idx_q     <= scan_idx_d;
      last_ch_q      <= last_ch_d;
      wait_first_q   <= wait_first_d;
      dac_send_q     <= dac_send_d;
      dac_data_q     <= dac_data_d;
      frame_active_q <= frame_active_d;
      overrun_q      <= overrun_d;
      ovw_q          <= ovw_d;
      dirty_q        <= dirty_d;
      sample_q       <= sample_d;
`ifdef DAC_LATCH_ALL_EN
      sent_mask_q    <= sent_mask_d;
      is_load_q      <= is_load_d;
`endif
    end
  end

  assign dac_send        = dac_send_q;
  assign dac_data        = dac_data_q;
  assign frame_active    = frame_active_q;
  assign frame_overrun   = overrun_q;
  assign overwrite_count = ovw_q;

endmodule
`default_nettype wire

// File: tb/tb_dac_channel_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_dac_channel_scheduler
// Description : Scoreboard bench for dac_channel_scheduler. Directed writes
//               push expected DAC words; a negedge monitor pops and compares
//               on every dac_send. A second small instance (NUM_CH=2)
//               covers ignored out-of-range channels.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dac_channel_scheduler;

  localparam int INTERVAL  = 100;
  localparam int INTERVAL2 = 16;
  localparam int BUSY_LEN  = 3;
`ifdef DAC_LATCH_ALL_EN
  localparam bit          LATCH_ALL = 1'b1;
`else
  localparam bit          LATCH_ALL = 1'b0;
`endif
  // Write-through words (0x3x) become write-code words (0x1x) with the macro.
  localparam logic [23:0] MODE_XOR  = LATCH_ALL ? 24'h200000 : 24'h000000;
  localparam int          FALL_AFTER_LAST = LATCH_ALL ? 5 : 6;
  localparam int          SENDS_ONE_CH    = LATCH_ALL ? 2 : 1;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        rstn;
  logic        in_valid;
  logic [1:0]  in_channel;
  logic [15:0] in_data;
  logic        busy_drv;
  logic        busy_hold;
  wire         spi_busy;
  wire         dac_send;
  wire  [23:0] dac_data;
  wire         frame_active;
  wire         frame_overrun;
  wire  [7:0]  overwrite_count;

  logic        in_valid2;
  logic [1:0]  in_channel2;
  logic [15:0] in_data2;
  logic        spi_busy2;
  wire         dac_send2;
  wire  [23:0] dac_data2;
  wire         frame_active2;
  wire         frame_overrun2;
  wire  [7:0]  overwrite_count2;

  assign spi_busy = busy_drv | busy_hold;

  dac_channel_scheduler #(
    .NUM_CH(4), .DATA_W(16), .INTERVAL(INTERVAL), .CNT_W(24)
  ) dut (
    .clock(clock), .rstn(rstn), .in_valid(in_valid), .in_channel(in_channel),
    .in_data(in_data), .spi_busy(spi_busy), .dac_send(dac_send),
    .dac_data(dac_data), .frame_active(frame_active),
    .frame_overrun(frame_overrun), .overwrite_count(overwrite_count)
  );

  dac_channel_scheduler #(
    .NUM_CH(2), .DATA_W(16), .INTERVAL(INTERVAL2), .CNT_W(8)
  ) dut2 (
    .clock(clock), .rstn(rstn), .in_valid(in_valid2), .in_channel(in_channel2),
    .in_data(in_data2), .spi_busy(spi_busy2), .dac_send(dac_send2),
    .dac_data(dac_data2), .frame_active(frame_active2),
    .frame_overrun(frame_overrun2), .overwrite_count(overwrite_count2)
  );

  int          checks = 0;
  int          errors = 0;
  int          sends_total = 0;
  int          sends2 = 0;
  int          cyc;
  int          send_log[$];
  logic [23:0] sb[$];
  logic [23:0] first_word2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push_load(input logic [3:0] mask);
    if (LATCH_ALL) sb.push_back({4'h2, mask, 16'h0000});
  endtask

  // Cycle index since reset release; the DUT timer equals cyc mod INTERVAL
  always @(posedge clock or negedge rstn) begin
    if (!rstn) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // SPI driver model: busy for BUSY_LEN cycles after each send pulse
  initial begin
    busy_drv = 1'b0;
    forever begin
      @(negedge clock);
      if (dac_send) begin
        busy_drv = 1'b1;
        repeat (BUSY_LEN) @(negedge clock);
        busy_drv = 1'b0;
      end
    end
  end

  // Scoreboard monitor
  always @(negedge clock) begin
    logic [23:0] exp_w;
    if (dac_send) begin
      sends_total++;
      send_log.push_back(cyc);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_send: got dac_data %h, expected no send", dac_data);
      end else begin
        exp_w = sb.pop_front();
        check("dac_data", {8'h0, dac_data}, {8'h0, exp_w});
      end
    end
  end

  always @(negedge clock) begin
    if (dac_send2) begin
      sends2++;
      if (sends2 == 1) first_word2 = dac_data2;
    end
  end

  task automatic write_sample(input logic [1:0] ch, input logic [15:0] d);
    in_valid = 1'b1; in_channel = ch; in_data = d;
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic write_sample2(input logic [1:0] ch, input logic [15:0] d);
    in_valid2 = 1'b1; in_channel2 = ch; in_data2 = d;
    @(negedge clock);
    in_valid2 = 1'b0;
  endtask

  // Wait for a frame to start (if not already) and then to end
  task automatic wait_frame(output int fall_cyc);
    int n;
    n = 0;
    while (!frame_active && n < 3 * INTERVAL) begin @(negedge clock); n++; end
    if (!frame_active) begin
      checks++; errors++;
      $display("FAIL frame_start_timeout: got frame_active 0, expected 1");
    end
    n = 0;
    while (frame_active && n < 8000) begin @(negedge clock); n++; end
    if (frame_active) begin
      checks++; errors++;
      $display("FAIL frame_end_timeout: got frame_active 1, expected 0");
    end
    fall_cyc = cyc;
  endtask

  initial begin
    int fall;
    int n;
    int s0;
    rstn = 1'b0; in_valid = 1'b0; in_channel = '0; in_data = '0; busy_hold = 1'b0;
    in_valid2 = 1'b0; in_channel2 = '0; in_data2 = '0; spi_busy2 = 1'b0;
    repeat (3) @(negedge clock);

    // Reset state
    check("rst_dac_send", {31'h0, dac_send}, 32'h0);
    check("rst_dac_data", {8'h0, dac_data}, 32'h0);
    check("rst_frame_active", {31'h0, frame_active}, 32'h0);
    check("rst_overrun", {31'h0, frame_overrun}, 32'h0);
    check("rst_ovw", {24'h0, overwrite_count}, 32'h0);
    rstn = 1'b1;
    repeat (4) @(negedge clock);

    // Single channel: send at tick+3, frame_active falls after completion
    send_log.delete();
    write_sample(2'd1, 16'h1234);
    sb.push_back(24'h321234 ^ MODE_XOR);
    push_load(4'b0010);
    wait_frame(fall);
    check("t1_send_count", send_log.size(), SENDS_ONE_CH);
    if (send_log.size() > 0) begin
      check("t1_send_phase", send_log[0] % INTERVAL, 2);
      check("t1_active_fall", fall, send_log[send_log.size()-1] + FALL_AFTER_LAST);
    end

    // Two channels go out in ascending order
    write_sample(2'd0, 16'hAAAA);
    write_sample(2'd3, 16'h5555);
    sb.push_back(24'h31AAAA ^ MODE_XOR);
    sb.push_back(24'h385555 ^ MODE_XOR);
    push_load(4'b1001);
    wait_frame(fall);
    check("t2_all_sent", sb.size(), 0);

    // Overwrite before the tick: counted once, only the newer value is sent
    write_sample(2'd2, 16'h1111);
    write_sample(2'd2, 16'h2222);
    check("t3_ovw_count", {24'h0, overwrite_count}, 32'd1);
    sb.push_back(24'h342222 ^ MODE_XOR);
    push_load(4'b0100);
    wait_frame(fall);
    check("t3_all_sent", sb.size(), 0);
    check("t3_no_overrun", {31'h0, frame_overrun}, 32'h0);

    // Write racing the SCAN latch of the same channel
    write_sample(2'd0, 16'h1111);
    sb.push_back(24'h311111 ^ MODE_XOR);
    push_load(4'b0001);
    n = 0;
    while ((cyc % INTERVAL) != 0 && n < 2 * INTERVAL) begin @(negedge clock); n++; end
    write_sample(2'd0, 16'h2222);
    wait_frame(fall);
    check("t7_old_sample_sent", sb.size(), 0);
    check("t7_ovw_unchanged", {24'h0, overwrite_count}, 32'd1);
    sb.push_back(24'h312222 ^ MODE_XOR);
    push_load(4'b0001);
    wait_frame(fall);
    check("t7_new_sample_next_frame", sb.size(), 0);

    // Driver stuck busy across many ticks: overrun, no extra frame
    send_log.delete();
    write_sample(2'd1, 16'hBEEF);
    busy_hold = 1'b1;
    sb.push_back(24'h32BEEF ^ MODE_XOR);
    push_load(4'b0010);
    n = 0;
    while (!frame_active && n < 3 * INTERVAL) begin @(negedge clock); n++; end
    repeat (5000) @(negedge clock);
    check("t4_overrun_set", {31'h0, frame_overrun}, 32'h1);
    check("t4_no_send_while_busy", send_log.size(), 0);
    busy_hold = 1'b0;
    wait_frame(fall);
    repeat (2 * INTERVAL) @(negedge clock);
    check("t4_send_count", send_log.size(), SENDS_ONE_CH);
    check("t4_overrun_sticky", {31'h0, frame_overrun}, 32'h1);

    // Reset during WAIT with another channel pending
    write_sample(2'd0, 16'h1357);
    sb.push_back(24'h311357 ^ MODE_XOR);
    n = 0;
    while (!dac_send && n < 3 * INTERVAL) begin @(negedge clock); n++; end
    check("t6_send_seen", {31'h0, dac_send}, 32'h1);
    in_valid = 1'b1; in_channel = 2'd3; in_data = 16'h9999;
    @(negedge clock);
    in_valid = 1'b0;
    rstn = 1'b0;
    @(negedge clock);
    check("t6_rst_dac_send", {31'h0, dac_send}, 32'h0);
    check("t6_rst_dac_data", {8'h0, dac_data}, 32'h0);
    check("t6_rst_frame_active", {31'h0, frame_active}, 32'h0);
    check("t6_rst_overrun", {31'h0, frame_overrun}, 32'h0);
    check("t6_rst_ovw", {24'h0, overwrite_count}, 32'h0);
    repeat (2) @(negedge clock);
    rstn = 1'b1;
    s0 = sends_total;
    repeat (2 * INTERVAL + 10) @(negedge clock);
    check("t6_no_send_after_reset", sends_total - s0, 0);
    write_sample(2'd2, 16'h4242);
    sb.push_back(24'h344242 ^ MODE_XOR);
    push_load(4'b0100);
    wait_frame(fall);
    check("t6_new_data_sent", sb.size(), 0);

    // NUM_CH=2 instance: channels 2 and 3 are ignored
    s0 = sends2;
    write_sample2(2'd3, 16'h7777);
    write_sample2(2'd3, 16'h7778);
    write_sample2(2'd2, 16'h7779);
    repeat (4 * INTERVAL2) @(negedge clock);
    check("t5_no_send", sends2 - s0, 0);
    check("t5_ovw_unchanged", {24'h0, overwrite_count2}, 32'h0);
    write_sample2(2'd1, 16'h0ABC);
    repeat (4 * INTERVAL2) @(negedge clock);
    check("t5_valid_ch_sent", sends2 - s0, SENDS_ONE_CH);
    check("t5_valid_ch_word", {8'h0, first_word2}, {8'h0, 24'h320ABC ^ MODE_XOR});

    check("final_scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
